// File: rtl/dest_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// dest_scoreboard_pkg
//   Shared constants for the WISC decode-stage destination scoreboard.
//   NREG      : number of architectural registers
//   REG_W     : register index width, equal to clog2(NREG)
//   CNT_W     : default width of each per-register pending-writer counter
//   LINK_REG  : architectural link register targeted by call instructions
// ----------------------------------------------------------------------------
package dest_scoreboard_pkg;

    localparam int NREG  = 8;
    localparam int REG_W = 3;
    localparam int CNT_W = 2;

    localparam logic [REG_W-1:0] LINK_REG = 3'd7;

    // Largest value a pending counter of the given width can hold.
    function automatic int cnt_limit(input int width);
        return (1 << width) - 1;
    endfunction

endpackage : dest_scoreboard_pkg

// File: rtl/dest_scoreboard_sb_counter.sv
// ----------------------------------------------------------------------------
// sb_counter
//   One pending-writer counter of the destination scoreboard. Counts up on an
//   accepted issue and down on each of two independent retire events
//   (writeback, kill); all three compose in a single cycle.
//
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   inc_i    in   accepted issue targets this register
//   dec_i    in   [0] writeback, [1] kill targets this register
//   zero_o   out  counter is 0
//   max_o    out  counter is at its largest value
//   uflow_o  out  the decrements this cycle exceed count + inc (counter will
//                 saturate at 0)
// ----------------------------------------------------------------------------
module sb_counter #(
    parameter int CNT_W = dest_scoreboard_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic [1:0] dec_i,
    output logic       zero_o,
    output logic       max_o,
    output logic       uflow_o
);

    localparam int                 EXT_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(dest_scoreboard_pkg::cnt_limit(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EXT_W-1:0] up_sum;
    logic [EXT_W-1:0] dec_sum;

    // One extra bit so count + inc never wraps before the decrements are
    // subtracted.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        cnt_d   = cnt_q;
        uflow_o = 1'b0;
        up_sum  = EXT_W'(cnt_q) + EXT_W'(inc_i);
        dec_sum = EXT_W'(dec_i[0]) + EXT_W'(dec_i[1]);
        if (up_sum < dec_sum) begin
            uflow_o = 1'b1;
            cnt_d   = '0;
        end else begin
            // The stall gate never lets inc land on a full counter, so the
            // difference always fits back into CNT_W bits.
            cnt_d = CNT_W'(up_sum - dec_sum);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its pre-edge inputs, independent of block order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign max_o  = (cnt_q == CNT_MAX);

endmodule : sb_counter

// File: rtl/dest_scoreboard.sv
// ----------------------------------------------------------------------------
// dest_scoreboard
//   Decode-stage scoreboard for the pipelined WISC core. Keeps one counter per
//   architectural register of in-flight instructions that will write it and
//   stalls decode on a read of a pending register or on a write that would
//   overflow that register's counter.
//
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   issue_valid  in   decode presents an instruction
//   issue_wr     in   presented instruction writes issue_rd
//   issue_rd     in   resolved destination index (LINK_REG for links)
//   rs_valid/rs  in   first source read
//   rt_valid/rt  in   second source read
//   wb_valid     in   writeback commits a write to wb_rd
//   kill_valid   in   squashed writer to kill_rd retires without writing
//   stall        out  combinational decode hold
//   busy         out  bit i set while counter i is nonzero
//   err          out  sticky underflow flag, cleared only by rst
// ----------------------------------------------------------------------------
module dest_scoreboard #(
    parameter int NREG  = dest_scoreboard_pkg::NREG,
    parameter int REG_W = dest_scoreboard_pkg::REG_W, // must equal clog2(NREG)
    parameter int CNT_W = dest_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             rs_valid,
    input  logic [REG_W-1:0] rs,
    input  logic             rt_valid,
    input  logic [REG_W-1:0] rt,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             kill_valid,
    input  logic [REG_W-1:0] kill_rd,
    output logic             stall,
    output logic [NREG-1:0]  busy,
    output logic             err
);

    import dest_scoreboard_pkg::*;

    logic [NREG-1:0] issue_oh, wb_oh, kill_oh;
    logic [NREG-1:0] cnt_zero, cnt_max, cnt_uflow;
    logic            issue_accept;
    logic            err_q, err_d;

    // Stall looks only at registered counters: a writeback in the same
    // cycle does not release it, release comes one cycle later.
    assign stall = issue_valid & ( (rs_valid & ~cnt_zero[rs])
                                 | (rt_valid & ~cnt_zero[rt])
                                 | (issue_wr &  cnt_max[issue_rd]) );

    assign issue_accept = issue_valid & issue_wr & ~stall;

    always_comb begin
        issue_oh = '0;
        wb_oh    = '0;
        kill_oh  = '0;
        for (int i = 0; i < NREG; i++) begin
            issue_oh[i] = issue_accept && (issue_rd == REG_W'(i));
            wb_oh[i]    = wb_valid     && (wb_rd    == REG_W'(i));
            kill_oh[i]  = kill_valid   && (kill_rd  == REG_W'(i));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (issue_oh[g]),
            .dec_i   ({kill_oh[g], wb_oh[g]}),
            .zero_o  (cnt_zero[g]),
            .max_o   (cnt_max[g]),
            .uflow_o (cnt_uflow[g])
        );
    end

    assign busy = ~cnt_zero;

    assign err_d = err_q | (|cnt_uflow);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and wins over any event in the same
        // cycle, so an underflow coinciding with rst never sets err.
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule : dest_scoreboard

// File: tb/tb_dest_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_dest_scoreboard
//   Directed sequence followed by a random phase; every cycle compares stall
//   (before the edge) and busy/err (after the edge) to a reference model that
//   keeps plain integer pending counts per register.
// ----------------------------------------------------------------------------
module tb_dest_scoreboard;

    import dest_scoreboard_pkg::*;

    localparam int MAXC = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid, issue_wr, rs_valid, rt_valid, wb_valid, kill_valid;
    logic [REG_W-1:0] issue_rd, rs, rt, wb_rd, kill_rd;
    logic             stall, err;
    logic [NREG-1:0]  busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_cnt [NREG];
    bit m_err;
    logic obs_stall;

    always #5 clk = ~clk;

    dest_scoreboard #(
        .NREG  (NREG),
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .rs_valid    (rs_valid),
        .rs          (rs),
        .rt_valid    (rt_valid),
        .rt          (rt),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .kill_valid  (kill_valid),
        .kill_rd     (kill_rd),
        .stall       (stall),
        .busy        (busy),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Spec-level stall rule over the model's pending counts.
    function automatic bit model_stall();
        if (!issue_valid) return 1'b0;
        if (rs_valid && m_cnt[rs] != 0) return 1'b1;
        if (rt_valid && m_cnt[rt] != 0) return 1'b1;
        if (issue_wr && m_cnt[issue_rd] == MAXC) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b;
        for (int i = 0; i < NREG; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    // One clock: drive at the falling edge, sample stall shortly after,
    // advance the model at the rising edge, then sample busy/err.
    task automatic cycle(input bit r,
                         input bit iv, input bit iw, input int ird,
                         input bit rsv, input int rsi,
                         input bit rtv, input int rti,
                         input bit wbv, input int wbr,
                         input bit kv,  input int kr);
        bit exp_stall, accept;
        int n;
        @(negedge clk);
        rst         = r;
        issue_valid = iv;  issue_wr = iw;  issue_rd = REG_W'(ird);
        rs_valid    = rsv; rs       = REG_W'(rsi);
        rt_valid    = rtv; rt       = REG_W'(rti);
        wb_valid    = wbv; wb_rd    = REG_W'(wbr);
        kill_valid  = kv;  kill_rd  = REG_W'(kr);
        #1;
        exp_stall = model_stall();
        obs_stall = stall;
        check("stall", 32'(stall), 32'(exp_stall));
        accept = iv && iw && !exp_stall;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                n = m_cnt[i] + ((accept && ird == i) ? 1 : 0)
                             - ((wbv && wbr == i) ? 1 : 0)
                             - ((kv && kr == i) ? 1 : 0);
                if (n < 0) begin
                    n = 0;
                    m_err = 1'b1;
                end
                m_cnt[i] = n;
            end
        end
        #1;
        check("busy", 32'(busy), 32'(model_busy()));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        cycle(0, 0,0,0, 0,0, 0,0, 0,0, 0,0);
    endtask

    task automatic do_reset();
        cycle(1, 0,0,0, 0,0, 0,0, 0,0, 0,0);
    endtask

    task automatic issue(input int rd);
        cycle(0, 1,1,rd, 0,0, 0,0, 0,0, 0,0);
    endtask

    initial begin
        int rd, wr, kr;
        rst = 1'b1;
        issue_valid = 0; issue_wr = 0; issue_rd = '0;
        rs_valid = 0; rs = '0; rt_valid = 0; rt = '0;
        wb_valid = 0; wb_rd = '0; kill_valid = 0; kill_rd = '0;
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_err = 1'b0;

        // Reset, then a single write to R3.
        do_reset();
        do_reset();
        check("rst_busy", 32'(busy), 32'h00);
        check("rst_err", 32'(err), 32'h0);
        issue(3);
        check("busy_r3", 32'(busy), 32'h08);
        idle();

        // Read of pending R3 with same-cycle writeback: still stalled, then released.
        cycle(0, 1,0,0, 1,3, 0,0, 1,3, 0,0);
        check("stall_wb_bypass", 32'(obs_stall), 32'h1);
        check("r3_cleared", 32'(busy), 32'h00);
        cycle(0, 1,0,0, 1,3, 0,0, 0,0, 0,0);
        check("stall_released", 32'(obs_stall), 32'h0);

        // Fill R5 to the maximum; the next write to R5 stalls, to R6 does not.
        issue(5); issue(5); issue(5);
        issue(5);
        check("stall_full", 32'(obs_stall), 32'h1);
        issue(6);
        check("stall_other", 32'(obs_stall), 32'h0);
        check("busy_r5_r6", 32'(busy), 32'h60);

        // Issue and writeback to R2 together leave its count unchanged.
        issue(2);
        cycle(0, 1,1,2, 0,0, 0,0, 1,2, 0,0);
        check("busy_r2_held", 32'(busy[2]), 32'h1);
        cycle(0, 0,0,0, 0,0, 0,0, 1,2, 0,0);
        check("busy_r2_free", 32'(busy[2]), 32'h0);

        // R4 at 2; writeback and kill together drop it to 0 without error.
        issue(4); issue(4);
        cycle(0, 0,0,0, 0,0, 0,0, 1,4, 1,4);
        check("busy_r4_zero", 32'(busy[4]), 32'h0);
        check("err_clear", 32'(err), 32'h0);
        cycle(0, 0,0,0, 0,0, 0,0, 1,4, 0,0);
        check("err_set", 32'(err), 32'h1);
        idle(); idle();
        check("err_sticky", 32'(err), 32'h1);

        // Link write pending, reset with an issue to the link register.
        do_reset();
        issue(int'(LINK_REG));
        check("busy_link", 32'(busy), 32'h80);
        cycle(1, 1,1,int'(LINK_REG), 0,0, 0,0, 0,0, 0,0);
        check("rst_busy2", 32'(busy), 32'h00);
        check("rst_err2", 32'(err), 32'h0);

        // Random phase: retires mostly target pending registers.
        for (int k = 0; k < 500; k++) begin
            rd = $urandom_range(NREG-1, 0);
            wr = $urandom_range(NREG-1, 0);
            kr = $urandom_range(NREG-1, 0);
            for (int t = 0; t < 4; t++) begin
                if (m_cnt[wr] == 0 && $urandom_range(3, 0) != 0) wr = $urandom_range(NREG-1, 0);
                if (m_cnt[kr] == 0 && $urandom_range(3, 0) != 0) kr = $urandom_range(NREG-1, 0);
            end
            cycle($urandom_range(59, 0) == 0,
                  $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, rd,
                  $urandom_range(1, 0) == 1, int'($urandom_range(NREG-1, 0)),
                  $urandom_range(2, 0) == 0, int'($urandom_range(NREG-1, 0)),
                  $urandom_range(2, 0) == 0, wr,
                  $urandom_range(5, 0) == 0, kr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dest_scoreboard

// File: doc/dest_scoreboard.md
Name: dest_scoreboard

Overview:
- Register-destination scoreboard for the pipelined WISC core; sits in decode, alongside the destination-select and register-file logic.
- Tracks how many in-flight instructions will write each architectural register.
- Raises a decode stall when an issuing instruction reads a pending register or would overflow a counter.
- Counters drop on writeback or on squash of a younger in-flight writer.

Parameters:
- NREG, 8, number of architectural registers.
- REG_W, 3, register index width; must equal clog2(NREG).
- CNT_W, 2, width of the per-register pending counter; maximum in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_wr  input  1  the presented instruction writes a register.
- issue_rd  input  REG_W  destination index, already resolved by destination select (R7 for link).
- rs_valid  input  1  instruction reads rs.
- rs  input  REG_W  first source index.
- rt_valid  input  1  instruction reads rt.
- rt  input  REG_W  second source index.
- wb_valid  input  1  writeback stage commits a register write.
- wb_rd  input  REG_W  register written back.
- kill_valid  input  1  a squashed in-flight instruction that had issue_wr set is retired without writing.
- kill_rd  input  REG_W  destination of the squashed instruction.
- stall  output  1  combinational; decode must hold the instruction.
- busy  output  NREG  bit i is set when counter i is nonzero (registered view).
- err  output  1  sticky underflow flag.

Behaviour:
- Reset (rst high at a clk edge): all counters 0, busy all 0, err 0. Reset overrides every other input that cycle.
- Reset mid-operation discards all pending state; upstream flushes the pipe concurrently.
- stall is asserted, combinationally, when issue_valid is high and any of the following hold:
  - rs_valid and counter[rs] is nonzero;
  - rt_valid and counter[rt] is nonzero;
  - issue_wr and counter[issue_rd] equals the maximum.
- stall is 0 when issue_valid is low.
- Bypass rule: a writeback or kill in the same cycle does NOT clear stall. stall uses registered counter values only. Release therefore occurs one cycle after the writeback.
- Issue accepted = issue_valid & issue_wr & ~stall. An accepted issue increments counter[issue_rd] at the next edge.
- Decrements: wb_valid decrements counter[wb_rd]; kill_valid decrements counter[kill_rd].
- Per-register next value = counter + inc - dec_wb - dec_kill, evaluated per register, so all simultaneous events compose:
  - issue and wb to the same register leave the counter unchanged;
  - wb and kill to the same register subtract 2.
- Underflow: if a decrement would take a counter below 0, the counter holds at 0 and err sets. err clears only on rst.
- Overflow is impossible by construction (the stall gate).
- busy is the OR-reduction of each counter and updates with the counters; latency is 1 cycle from event to busy change.
- No hazard on R0 is special-cased; every register is general.

Decomposition:
- Shared package holds:
  - WISC constants NREG, REG_W;
  - link register index LINK_REG = 3'd7;
  - CNT_W default.
- One sub-module, sb_counter: a single CNT_W up/down counter with inc, dec[1:0], sync rst, zero/max/underflow outputs, instantiated NREG times.
- Top level holds:
  - index decoders (one-hot for issue_rd, wb_rd, kill_rd);
  - the stall logic;
  - the err register.

Test Plan:
- Reset → busy=8'h00, err=0, stall=0. Then issue_wr with rd=3, no sources → next cycle busy=8'h08, stall=0.
- Counter[3]=1; issue with rs_valid, rs=3 → stall=1. Apply wb_valid, wb_rd=3 the same cycle → stall still 1 that cycle, counter 0 next cycle, stall=0 the cycle after.
- Issue rd=5 three times, no wb → counter[5]=3. Fourth issue to rd=5 → stall=1. Fourth issue to rd=6 → stall=0, accepted.
- Counter[2]=1; same cycle: accepted issue rd=2 and wb_rd=2 → counter[2] stays 1, busy[2]=1.
- Counter[4]=2; wb_rd=4 and kill_rd=4 same cycle → counter[4]=0, busy[4]=0, err=0. Then wb_rd=4 again → err=1 and stays 1 until rst.
- Counter[7]=1 from a link write; assert rst while issue_valid targets rd=7 → busy=0, err=0 next cycle, the issue is not recorded.
